// File: rtl/load_diffusion_errors_pkg.sv
// Shared widths and FSM state encodings for the diffusion-error loader.
package load_diffusion_errors_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_CLEAR = 5'b00010,
        S_RD    = 5'b00100,
        S_WAIT  = 5'b01000,
        S_LATCH = 5'b10000
    } state_e;

endpackage

// File: rtl/load_diffusion_errors.sv
// Loads top/left diffusion errors for one macroblock column from the top-line RAM,
// and zeroes that RAM at frame start. All outputs are registered.
module load_diffusion_errors
    import load_diffusion_errors_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] x,
    input  logic [DATA_W-1:0] left_derr_in,
    input  logic              clear,
    input  logic [ADDR_W-1:0] mb_w,
    input  logic [DATA_W-1:0] top_derr_rdata,
    output logic              top_derr_en,
    output logic              top_derr_wea,
    output logic [ADDR_W-1:0] top_derr_addr,
    output logic [DATA_W-1:0] top_derr_wdata,
    output logic [DATA_W-1:0] top_derr,
    output logic [DATA_W-1:0] left_derr,
    output logic              done,
    output logic              clear_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] capX_q, capX_d;
    logic [DATA_W-1:0] capLeft_q, capLeft_d;
    logic [DATA_W-1:0] topDerr_q, topDerr_d;
    logic [DATA_W-1:0] leftDerr_q, leftDerr_d;
    logic              done_q, done_d;
    logic              clearDone_q, clearDone_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        wea_d       = wea_q;
        addr_d      = addr_q;
        capX_d      = capX_q;
        capLeft_d   = capLeft_q;
        topDerr_d   = topDerr_q;
        leftDerr_d  = leftDerr_q;
        done_d      = 1'b0;
        clearDone_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    addr_d  = '0;
                    if (mb_w == '0) begin
                        en_d        = 1'b0;
                        wea_d       = 1'b0;
                        clearDone_d = 1'b1;
                    end else begin
                        en_d  = 1'b1;
                        wea_d = 1'b1;
                    end
                end else if (start) begin
                    state_d   = S_RD;
                    en_d      = 1'b1;
                    wea_d     = 1'b0;
                    addr_d    = x;
                    capX_d    = x;
                    capLeft_d = left_derr_in;
                end
            end
            // The write currently on the bus is the last one when cnt reaches mb_w-1.
            S_CLEAR: begin
                if (clearDone_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == mb_w - 10'd1) begin
                    en_d        = 1'b0;
                    wea_d       = 1'b0;
                    clearDone_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 10'd1;
                    addr_d = cnt_q + 10'd1;
                end
            end
            S_RD: begin
                en_d    = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                topDerr_d  = top_derr_rdata;
                leftDerr_d = (capX_q == '0) ? '0 : capLeft_q;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                wea_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            wea_q       <= 1'b0;
            addr_q      <= '0;
            capX_q      <= '0;
            capLeft_q   <= '0;
            topDerr_q   <= '0;
            leftDerr_q  <= '0;
            done_q      <= 1'b0;
            clearDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            wea_q       <= wea_d;
            addr_q      <= addr_d;
            capX_q      <= capX_d;
            capLeft_q   <= capLeft_d;
            topDerr_q   <= topDerr_d;
            leftDerr_q  <= leftDerr_d;
            done_q      <= done_d;
            clearDone_q <= clearDone_d;
        end
    end

    assign top_derr_en    = en_q;
    assign top_derr_wea   = wea_q;
    assign top_derr_addr  = addr_q;
    assign top_derr_wdata = '0;
    assign top_derr       = topDerr_q;
    assign left_derr      = leftDerr_q;
    assign done           = done_q;
    assign clear_done     = clearDone_q;

endmodule

// File: tb/tb_load_diffusion_errors.sv
// Self-checking bench: directed scenarios plus randomized loads/clears against a RAM-content model.
module tb_load_diffusion_errors;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  x = '0;
    logic [31:0] left_derr_in = '0;
    logic        clear = 1'b0;
    logic [9:0]  mb_w = '0;
    logic [31:0] top_derr_rdata;
    logic        top_derr_en;
    logic        top_derr_wea;
    logic [9:0]  top_derr_addr;
    logic [31:0] top_derr_wdata;
    logic [31:0] top_derr;
    logic [31:0] left_derr;
    logic        done;
    logic        clear_done;

    int checks = 0;
    int failures = 0;

    // Expected RAM contents, updated from what loads and clears should do.
    logic [31:0] modelMem [1024];

    logic [31:0] ram [1024];
    logic [31:0] rdataQ = '0;
    logic        tbWe = 1'b0;
    logic [9:0]  tbAddr = '0;
    logic [31:0] tbData = '0;

    always #5 clk = ~clk;

    load_diffusion_errors dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .x              (x),
        .left_derr_in   (left_derr_in),
        .clear          (clear),
        .mb_w           (mb_w),
        .top_derr_rdata (top_derr_rdata),
        .top_derr_en    (top_derr_en),
        .top_derr_wea   (top_derr_wea),
        .top_derr_addr  (top_derr_addr),
        .top_derr_wdata (top_derr_wdata),
        .top_derr       (top_derr),
        .left_derr      (left_derr),
        .done           (done),
        .clear_done     (clear_done)
    );

    // Synchronous single-port RAM with a backdoor write port for preloading.
    always @(posedge clk) begin
        if (tbWe) begin
            ram[tbAddr] <= tbData;
        end else if (top_derr_en) begin
            if (top_derr_wea) ram[top_derr_addr] <= top_derr_wdata;
            else              rdataQ <= ram[top_derr_addr];
        end
    end
    assign top_derr_rdata = rdataQ;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        tbWe = 1'b1; tbAddr = a; tbData = d;
        @(negedge clk);
        tbWe = 1'b0;
        modelMem[a] = d;
    endtask

    // Load with the fixed three-edge latency; inputs are scrambled after the request to prove capture.
    task automatic applyStimulus(input logic [9:0] xv, input logic [31:0] lv, input string tag);
        logic [31:0] expTop;
        logic [31:0] expLeft;
        expTop  = modelMem[xv];
        expLeft = (xv == 10'd0) ? 32'd0 : lv;
        @(negedge clk);
        x = xv; left_derr_in = lv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = 10'($urandom); left_derr_in = $urandom;
        checkOutput({tag, "_rd_en"}, 32'(top_derr_en), 32'd1);
        checkOutput({tag, "_rd_wea"}, 32'(top_derr_wea), 32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(top_derr_addr), 32'(xv));
        @(negedge clk);
        checkOutput({tag, "_wait_en"}, 32'(top_derr_en), 32'd0);
        checkOutput({tag, "_early_done1"}, 32'(done), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_early_done2"}, 32'(done), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_top"}, top_derr, expTop);
        checkOutput({tag, "_left"}, left_derr, expLeft);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_top_hold"}, top_derr, expTop);
    endtask

    task automatic applyClear(input logic [9:0] n, input logic withStart, input string tag);
        int doneSeen;
        doneSeen = 0;
        @(negedge clk);
        clear = 1'b1; mb_w = n; start = withStart; x = 10'd1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            checkOutput($sformatf("%s_w%0d_en", tag, k), 32'({top_derr_en, top_derr_wea}), 32'd3);
            checkOutput($sformatf("%s_w%0d_addr", tag, k), 32'(top_derr_addr), 32'(k));
            checkOutput($sformatf("%s_w%0d_cd", tag, k), 32'(clear_done), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_cd"}, 32'(clear_done), 32'd1);
        checkOutput({tag, "_cd_en"}, 32'({top_derr_en, top_derr_wea}), 32'd0);
        for (int k = 0; k < int'(n); k++) modelMem[k] = 32'd0;
        @(negedge clk);
        checkOutput({tag, "_cd_pulse"}, 32'(clear_done), 32'd0);
        if (withStart) begin
            for (int k = 0; k < 6; k++) begin
                if (done) doneSeen++;
                @(negedge clk);
            end
            checkOutput({tag, "_no_done"}, 32'(doneSeen), 32'd0);
        end
    endtask

    initial begin
        int doneCount;
        int cdCount;

        #12;
        checkOutput("rst_en", 32'({top_derr_en, top_derr_wea}), 32'd0);
        checkOutput("rst_addr", 32'(top_derr_addr), 32'd0);
        checkOutput("rst_top", top_derr, 32'd0);
        checkOutput("rst_left", left_derr, 32'd0);
        checkOutput("rst_pulses", 32'({done, clear_done}), 32'd0);
        checkOutput("rst_wdata", top_derr_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) preload(10'(a), $urandom);
        preload(10'd5, 32'h04FD0201);
        preload(10'd0, 32'h01010101);

        applyStimulus(10'd5, 32'h11223344, "load_x5");
        applyStimulus(10'd0, 32'hFFFFFFFF, "row_start");

        applyClear(10'd3, 1'b0, "clear3");
        applyStimulus(10'd2, 32'hA5A5A5A5, "after_clear");
        applyStimulus(10'd3, 32'h80808080, "beyond_clear");

        applyClear(10'd0, 1'b1, "clear_start");

        // A second start while waiting for read data must be dropped, not queued.
        doneCount = 0;
        @(negedge clk);
        x = 10'd3; left_derr_in = 32'h0BADF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 10'd7; left_derr_in = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) doneCount++;
            @(negedge clk);
        end
        checkOutput("wait_start_done_count", 32'(doneCount), 32'd1);
        checkOutput("wait_start_top", top_derr, modelMem[3]);
        checkOutput("wait_start_left", left_derr, 32'h0BADF00D);

        // Reset in the middle of a clear aborts it at once.
        @(negedge clk);
        clear = 1'b1; mb_w = 10'd4;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checkOutput("rstclr_addr1", 32'(top_derr_addr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstclr_en", 32'({top_derr_en, top_derr_wea}), 32'd0);
        checkOutput("rstclr_addr", 32'(top_derr_addr), 32'd0);
        checkOutput("rstclr_data", top_derr | left_derr, 32'd0);
        checkOutput("rstclr_pulses", 32'({done, clear_done}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cdCount = 0;
        for (int k = 0; k < 6; k++) begin
            if (clear_done || top_derr_en) cdCount++;
            @(negedge clk);
        end
        checkOutput("rstclr_idle_quiet", 32'(cdCount), 32'd0);

        for (int a = 0; a < 16; a++) preload(10'(a), $urandom);
        applyStimulus(10'd9, 32'hCAFEF00D, "post_reset_load");

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0)
                applyClear(10'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $sformatf("rnd_clear%0d", it));
            else
                applyStimulus(10'($urandom_range(0, 15)), $urandom, $sformatf("rnd_load%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_diffusion_errors.md
LOAD_DIFFUSION_ERRORS -- requirements
Module: load_diffusion_errors

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic rises on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, one-cycle request to load errors for macroblock column x.
REQ-004 SHALL have port x, input, 10, macroblock column, also the top-line RAM address.
REQ-005 SHALL have port left_derr_in, input, 32, packed left errors {l3,l2,l1,l0}, signed 8-bit each, held by the storing block.
REQ-006 SHALL have port clear, input, 1, one-cycle request to zero the top-line RAM at frame start.
REQ-007 SHALL have port mb_w, input, 10, number of RAM entries to clear.
REQ-008 SHALL have port top_derr_rdata, input, 32, RAM read data, valid one cycle after en=1 with wea=0.
REQ-009 SHALL have port top_derr_en, output, 1, RAM enable.
REQ-010 SHALL have port top_derr_wea, output, 1, RAM write enable, used only by clear.
REQ-011 SHALL have port top_derr_addr, output, 10, RAM address.
REQ-012 SHALL have port top_derr_wdata, output, 32, RAM write data, always 0.
REQ-013 SHALL have port top_derr, output, 32, loaded {t3,t2,t1,t0}.
REQ-014 SHALL have port left_derr, output, 32, loaded {l3,l2,l1,l0}.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when top_derr/left_derr are valid.
REQ-016 SHALL have port clear_done, output, 1, one-cycle pulse when clearing completes.

Function
REQ-017 SHALL implement the one-hot FSM IDLE, CLEAR, RD, WAIT, LATCH.
REQ-018 IDLE: clear -> CLEAR; else start -> RD; clear wins when both are high.
REQ-019 RD: register en=1, wea=0, addr=x, and capture x and left_derr_in; next state WAIT.
REQ-020 WAIT: drive en=0; next state LATCH.
REQ-021 LATCH: register top_derr=top_derr_rdata, register left_derr=(captured x==0 ? 0 : captured left_derr_in), pulse done=1; next state IDLE.
REQ-022 done SHALL rise on the third rising edge after start is sampled; this latency is fixed.
REQ-023 top_derr/left_derr SHALL hold their values until the next LATCH.
REQ-024 CLEAR: write en=1, wea=1, wdata=0 to addr 0..mb_w-1, one per cycle, ascending, using a 10-bit counter.
REQ-025 CLEAR: after addr mb_w-1 is written, pulse clear_done on the next cycle with en=wea=0, then go to IDLE.
REQ-026 mb_w==0: perform no write and pulse clear_done on the cycle after CLEAR is entered.
REQ-027 start or clear received outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 Data is passed through bit-exact, with no arithmetic or saturation; each byte is treated as signed 8-bit only by the consumer.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in IDLE and every output and the counter SHALL be 0.
REQ-030 Reset asserted mid-CLEAR or mid-load SHALL abort the operation immediately, with no done or clear_done pulse; the RAM contents are then undefined until the next clear.

Structure
REQ-031 A shared package SHALL hold the state encodings, the address width (10) and the data width (32).
REQ-032 The block SHALL be a single module with no sub-module; the clear counter is inline.

Verification
REQ-033 Load: RAM[5]=0x04FD0201, left_derr_in=0x11223344, start with x=5 -> addr=5 read, done on edge 3, top_derr=0x04FD0201, left_derr=0x11223344.
REQ-034 Row start: x=0, left_derr_in=0xFFFFFFFF, RAM[0]=0x01010101 -> left_derr=0, top_derr=0x01010101.
REQ-035 Clear: mb_w=3, prefilled RAM -> writes of 0 to addr 0,1,2 on consecutive cycles, clear_done on the 4th cycle after entry, later load x=2 returns 0.
REQ-036 Simultaneous clear and start, mb_w=0 -> clear path taken, clear_done with no write, no done pulse.
REQ-037 start pulsed during WAIT -> ignored, exactly one done pulse.
REQ-038 rst_n low during CLEAR at addr 1 -> all outputs 0 immediately, no clear_done, IDLE after release.
